ov5640_init_sequencer: RTL and testbench
========================================

Name: ov5640_init_sequencer

Overview:
- Reader side of the OV5640 RGB init register table. Walks the table from index 0 to INIT_REG_NUM-1.
- Each 24-bit entry is split as {reg_addr[15:0], data[7:0]} and issued as one SCCB write request to the existing SCCB master.
- Inserts the power-up and software-reset settle delays the sensor requires, retries NACKed writes, and reports done/error to the camera top level.

Parameters:
- ADDR_WIDTH, 8, table address width.
- DATA_WIDTH, 24, table word width; fixed layout {reg16, data8}.
- INIT_REG_NUM, 252, number of valid table entries.
- PWRUP_DELAY_CYC, 1_000_000, cycles to wait after start before the first write (20 ms at 50 MHz).
- SWRST_DELAY_CYC, 250_000, cycles to wait after a write to reg 0x3008 with data bit7=1 (5 ms at 50 MHz).
- MAX_RETRY, 3, number of re-issues allowed per entry after a NACK.

Ports:
- clk  in  1  system clock; one clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; starts or restarts the sequence.
- table_addr  out  ADDR_WIDTH  table ROM address.
- table_q  in  DATA_WIDTH  table ROM data; registered, valid 1 clk after table_addr.
- sccb_req  out  1  single-cycle write request to the SCCB master.
- sccb_reg_addr  out  16  register address for the write.
- sccb_wdata  out  8  write data.
- sccb_done  in  1  single-cycle pulse; the transaction has finished.
- sccb_nack  in  1  sampled together with sccb_done; 1 means the slave NACKed.
- busy  out  1  high from start acceptance until DONE or ERROR.
- init_done  out  1  level; all entries written successfully.
- init_error  out  1  level; retries exhausted on an entry.
- progress  out  ADDR_WIDTH  index of the entry currently in progress.

Behaviour:
- Reset values: all outputs 0; state IDLE; delay counter, retry counter and index all 0.
- States: IDLE, PWRUP, FETCH, LATCH, ISSUE, WAIT, SETTLE, NEXT, DONE, ERROR.
- IDLE: on start, index<=0, cnt<=0, busy<=1, go to PWRUP.
- PWRUP: count to PWRUP_DELAY_CYC-1, then go to FETCH.
- FETCH: table_addr<=index; go to LATCH. LATCH waits exactly 1 cycle for ROM latency, then captures table_q into sccb_reg_addr/sccb_wdata. Total fetch latency is 2 clk.
- ISSUE: sccb_req=1 for exactly one cycle; go to WAIT.
- WAIT: hold reg_addr/wdata stable until sccb_done.
  - done with nack=0: if reg==16'h3008 and data[7]==1, go to SETTLE; otherwise go to NEXT.
  - done with nack=1 and retry<MAX_RETRY: retry++, go to ISSUE (the entry is not re-fetched).
  - done with nack=1 and retry==MAX_RETRY: go to ERROR.
- SETTLE: count to SWRST_DELAY_CYC-1, then go to NEXT.
- NEXT: retry<=0. If index==INIT_REG_NUM-1, go to DONE; else index++ and go to FETCH. index never wraps and never reads beyond INIT_REG_NUM-1.
- DONE: init_done=1, busy=0, hold. ERROR: init_error=1, busy=0, progress frozen at the failing index, hold.
- start in DONE or ERROR: clear the flags and restart from PWRUP, index 0.
- start in any busy state: ignored. It is never allowed to truncate an in-flight SCCB transaction.
- sccb_done outside WAIT: ignored.
- Delay counters are 32 bits wide; a parameter value of 0 is treated as 1 cycle.
- reset_n low mid-operation: immediate return to IDLE with all outputs 0. sccb_req drops the same cycle (asynchronous clear).
- progress = index at all times.

Decomposition:
- Shared package ov5640_init_pkg holds:
  - state enum;
  - SWRST_REG = 16'h3008;
  - SWRST_BIT = 7;
  - entry field slicing constants REG_MSB=23, REG_LSB=8, DAT_MSB=7.
- One sub-module, init_delay_counter: load/count/expire, 32-bit. It is instantiated once and shared by PWRUP and SETTLE (the two states are mutually exclusive).

Test Plan:
- Sim params PWRUP=10, SWRST=20, INIT_REG_NUM=4, behavioral 4-entry ROM {3103_11, 3008_82, 3008_42, 4740_20}, SCCB model answering done 5 clk after req, nack=0.
  -> first req exactly 10+2+1 clk after start; 4 reqs with correct addr/data; init_done after the 4th.
- Same setup: measure the gap between the done for entry 1 (3008_82) and the next req.
  -> gap = 20 SETTLE + 1 NEXT + 2 fetch + 1 = 24 clk; the gap after entry 2 (3008_42, bit7=0) carries no SETTLE.
- Model NACKs entry 2 twice, then ACKs.
  -> 3 reqs with identical 3008_42; the sequence completes; init_done=1, init_error=0.
- Model NACKs entry 0 four times.
  -> exactly 4 reqs; init_error=1, busy=0, progress=0, init_done=0; no further reqs.
- Assert reset_n low while in WAIT on entry 2, release, then pulse start.
  -> all outputs 0 during reset; the sequence restarts at index 0 with the PWRUP delay.
- Pulse start while busy, and inject spurious sccb_done in FETCH.
  -> no restart, no extra req, req/done count stays 1:1.

Source files
------------

// File: rtl/ov5640_init_pkg.sv
// Shared definitions for the OV5640 init-table sequencer: FSM states, soft-reset
// detection constants, table entry field positions and the delay-limit helper.
package ov5640_init_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PWRUP,
        ST_FETCH,
        ST_LATCH,
        ST_ISSUE,
        ST_WAIT,
        ST_SETTLE,
        ST_NEXT,
        ST_DONE,
        ST_ERROR
    } init_state_e;

    localparam logic [15:0] SWRST_REG = 16'h3008;
    localparam int          SWRST_BIT = 7;

    localparam int REG_MSB = 23;
    localparam int REG_LSB = 8;
    localparam int DAT_MSB = 7;

    // A delay of 0 cycles behaves like a 1-cycle delay.
    function automatic logic [31:0] delay_last(input logic [31:0] cyc);
        return (cyc == 32'd0) ? 32'd0 : cyc - 32'd1;
    endfunction

endpackage

// File: rtl/init_delay_counter.sv
// Shared 32-bit settle-delay counter: load clears, en counts up and stops at limit-1.
// expired_o is combinational from the count; no backpressure.
module init_delay_counter
    import ov5640_init_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load_i,
    input  logic        en_i,
    input  logic [31:0] limit_i,
    output logic        expired_o
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    assign expired_o = (cnt_q == delay_last(limit_i));

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ov5640_init_sequencer.sv
// Walks the OV5640 init table and issues one SCCB write per entry, with power-up and
// soft-reset settle delays and bounded NACK retries; waits indefinitely on sccb_done.
module ov5640_init_sequencer
    import ov5640_init_pkg::*;
#(
    parameter int ADDR_WIDTH      = 8,
    parameter int DATA_WIDTH      = 24,
    parameter int INIT_REG_NUM    = 252,
    parameter int PWRUP_DELAY_CYC = 1_000_000,
    parameter int SWRST_DELAY_CYC = 250_000,
    parameter int MAX_RETRY       = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] table_addr,
    input  logic [DATA_WIDTH-1:0] table_q,
    output logic                  sccb_req,
    output logic [15:0]           sccb_reg_addr,
    output logic [7:0]            sccb_wdata,
    input  logic                  sccb_done,
    input  logic                  sccb_nack,
    output logic                  busy,
    output logic                  init_done,
    output logic                  init_error,
    output logic [ADDR_WIDTH-1:0] progress
);

    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RETRY_W-1:0]    RETRY_MAX = RETRY_W'(MAX_RETRY);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(INIT_REG_NUM - 1);

    init_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] index_q, index_d;
    logic [RETRY_W-1:0]    retry_q, retry_d;
    logic [15:0]           reg_addr_q, reg_addr_d;
    logic [7:0]            wdata_q, wdata_d;

    logic        cnt_load;
    logic        cnt_en;
    logic        cnt_expired;
    logic [31:0] cnt_limit;

    // PWRUP and SETTLE never overlap, so one counter serves both.
    assign cnt_limit = (state_q == ST_SETTLE) ? 32'(SWRST_DELAY_CYC) : 32'(PWRUP_DELAY_CYC);

    init_delay_counter u_delay (
        .clk       (clk),
        .reset_n   (reset_n),
        .load_i    (cnt_load),
        .en_i      (cnt_en),
        .limit_i   (cnt_limit),
        .expired_o (cnt_expired)
    );

    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        retry_d    = retry_q;
        reg_addr_d = reg_addr_q;
        wdata_d    = wdata_q;
        cnt_load   = 1'b0;
        cnt_en     = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d  = ST_PWRUP;
                    index_d  = '0;
                    retry_d  = '0;
                    cnt_load = 1'b1;
                end
            end
            ST_PWRUP: begin
                cnt_en = 1'b1;
                if (cnt_expired) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_LATCH;
            ST_LATCH: begin
                reg_addr_d = table_q[REG_MSB:REG_LSB];
                wdata_d    = table_q[DAT_MSB:0];
                state_d    = ST_ISSUE;
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (sccb_done) begin
                    if (!sccb_nack) begin
                        if (reg_addr_q == SWRST_REG && wdata_q[SWRST_BIT]) begin
                            state_d  = ST_SETTLE;
                            cnt_load = 1'b1;
                        end else begin
                            state_d = ST_NEXT;
                        end
                    end else if (retry_q < RETRY_MAX) begin
                        // Re-issue from the held registers; the entry is not re-read.
                        retry_d = retry_q + 1'b1;
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_SETTLE: begin
                cnt_en = 1'b1;
                if (cnt_expired) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                retry_d = '0;
                if (index_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    index_d = index_q + 1'b1;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            index_q    <= '0;
            retry_q    <= '0;
            reg_addr_q <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            retry_q    <= retry_d;
            reg_addr_q <= reg_addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign sccb_req      = (state_q == ST_ISSUE);
    assign sccb_reg_addr = reg_addr_q;
    assign sccb_wdata    = wdata_q;
    assign table_addr    = index_q;
    assign progress      = index_q;
    assign init_done     = (state_q == ST_DONE);
    assign init_error    = (state_q == ST_ERROR);
    assign busy          = !(state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERROR);

endmodule

// File: tb/tb_ov5640_init_sequencer.sv
// Bench for ov5640_init_sequencer: behavioural ROM and SCCB responder, a timing
// reference model computed per run, table-driven scenarios and random runs.
module tb_ov5640_init_sequencer;

    localparam int NREG = 4;
    localparam int PWR  = 10;
    localparam int SWR  = 20;
    localparam int MAXR = 3;
    localparam int LAT  = 5;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [7:0]  table_addr;
    logic [23:0] table_q;
    logic        sccb_req;
    logic [15:0] sccb_reg_addr;
    logic [7:0]  sccb_wdata;
    logic        sccb_done;
    logic        sccb_nack;
    logic        busy;
    logic        init_done;
    logic        init_error;
    logic [7:0]  progress;

    always #5 clk = ~clk;

    ov5640_init_sequencer #(
        .ADDR_WIDTH      (8),
        .DATA_WIDTH      (24),
        .INIT_REG_NUM    (NREG),
        .PWRUP_DELAY_CYC (PWR),
        .SWRST_DELAY_CYC (SWR),
        .MAX_RETRY       (MAXR)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .table_addr    (table_addr),
        .table_q       (table_q),
        .sccb_req      (sccb_req),
        .sccb_reg_addr (sccb_reg_addr),
        .sccb_wdata    (sccb_wdata),
        .sccb_done     (sccb_done),
        .sccb_nack     (sccb_nack),
        .busy          (busy),
        .init_done     (init_done),
        .init_error    (init_error),
        .progress      (progress)
    );

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    logic [23:0] rom [NREG];
    always @(posedge clk) table_q <= rom[table_addr[1:0]];
    always @(posedge clk) cyc <= cyc + 1;

    // Per-request responder plan (request order) and logs of observed requests.
    bit          plan_nack[$];
    int          plan_lat[$];
    int          req_cyc[$];
    logic [15:0] req_addr[$];
    logic [7:0]  req_dat[$];
    int          rsp_p    = 0;
    bit          pend     = 1'b0;
    bit          pend_nk  = 1'b0;
    int          pend_cyc = 0;
    int          spur_cyc = -1;

    // Reference model results.
    int          exp_cyc[$];
    logic [15:0] exp_addr[$];
    logic [7:0]  exp_dat[$];
    bit          m_done;
    bit          m_err;
    int          m_end;
    int          m_prog;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic bit nack_of(input int p);
        return (p < plan_nack.size()) ? plan_nack[p] : 1'b0;
    endfunction

    function automatic int lat_of(input int p);
        return (p < plan_lat.size()) ? plan_lat[p] : LAT;
    endfunction

    // SCCB slave model: done (and nack) LAT clocks after each observed request.
    always @(negedge clk) begin
        sccb_done = 1'b0;
        sccb_nack = 1'b0;
        if (!reset_n) begin
            pend = 1'b0;
        end else begin
            if (pend && cyc == pend_cyc) begin
                sccb_done = 1'b1;
                sccb_nack = pend_nk;
                pend      = 1'b0;
                chk("hold_in_wait", {sccb_reg_addr, sccb_wdata}, {req_addr[$], req_dat[$]});
            end else if (cyc == spur_cyc) begin
                sccb_done = 1'b1;
            end
            if (sccb_req) begin
                req_cyc.push_back(cyc);
                req_addr.push_back(sccb_reg_addr);
                req_dat.push_back(sccb_wdata);
                pend     = 1'b1;
                pend_cyc = cyc + lat_of(rsp_p);
                pend_nk  = nack_of(rsp_p);
                rsp_p++;
            end
        end
    end

    // Timeline from the start cycle s: power-up, 2-cycle fetch, issue; done after the
    // plan's latency; NACK -> re-issue next cycle; ACK -> optional settle, then next entry.
    task automatic model_run(input int s);
        int t, d, p, a, settle;
        exp_cyc.delete();
        exp_addr.delete();
        exp_dat.delete();
        m_done = 1'b0;
        m_err  = 1'b0;
        m_end  = 0;
        m_prog = 0;
        d = 0;
        p = 0;
        t = s + 1 + ((PWR < 1) ? 1 : PWR) + 2;
        for (int e = 0; e < NREG; e++) begin
            a = 0;
            m_prog = e;
            while (1'b1) begin
                exp_cyc.push_back(t);
                exp_addr.push_back(rom[e][23:8]);
                exp_dat.push_back(rom[e][7:0]);
                d = t + lat_of(p);
                if (!nack_of(p)) begin
                    p++;
                    break;
                end
                p++;
                if (a == MAXR) begin
                    m_err = 1'b1;
                    m_end = d + 1;
                    return;
                end
                a++;
                t = d + 1;
            end
            settle = (rom[e][23:8] == 16'h3008 && rom[e][7]) ? ((SWR < 1) ? 1 : SWR) : 0;
            t = d + settle + 4;
            if (e == NREG - 1) begin
                m_done = 1'b1;
                m_end  = d + settle + 2;
            end
        end
    endtask

    task automatic build_plan(input logic [11:0] nk);
        int n;
        plan_nack.delete();
        plan_lat.delete();
        for (int e = 0; e < NREG; e++) begin
            n = int'(nk[e*3 +: 3]);
            for (int j = 0; j < n && j <= MAXR; j++) begin
                plan_nack.push_back(1'b1);
                plan_lat.push_back(LAT);
            end
            plan_nack.push_back(1'b0);
            plan_lat.push_back(LAT);
        end
    endtask

    int last_s;

    // One full sequence; bso = start pulse offset while busy, spur = spurious done offset.
    task automatic run_and_check(input string nm, input int bso, input int spur);
        int s, budget;
        req_cyc.delete();
        req_addr.delete();
        req_dat.delete();
        rsp_p = 0;
        @(negedge clk);
        s = cyc;
        last_s = s;
        model_run(s);
        spur_cyc = (spur >= 0) ? s + spur : -1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({nm, "_after_start"}, {busy, init_done, init_error}, 3'b100);
        budget = 0;
        while (!(init_done || init_error) && budget < 3000) begin
            start = (bso >= 0 && cyc == s + bso);
            @(negedge clk);
            budget++;
        end
        start = 1'b0;
        spur_cyc = -1;
        chk({nm, "_end_cycle"}, 64'(cyc), 64'(m_end));
        chk({nm, "_flags"}, {init_done, init_error, busy}, {m_done, m_err, 1'b0});
        chk({nm, "_progress"}, 64'(progress), 64'(m_prog));
        repeat (30) @(negedge clk);
        chk({nm, "_req_count"}, 64'(req_cyc.size()), 64'(exp_cyc.size()));
        for (int i = 0; i < exp_cyc.size() && i < req_cyc.size(); i++) begin
            chk($sformatf("%s_req%0d", nm, i),
                {32'(req_cyc[i]), req_addr[i], req_dat[i]},
                {32'(exp_cyc[i]), exp_addr[i], exp_dat[i]});
        end
    endtask

    typedef struct {
        logic [11:0] nk;
        int          bso;
        int          spur;
        int          reqs;
        bit          done;
        bit          err;
        int          prog;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int b;
        vecs[0] = '{12'h000, -1, -1, 4, 1'b1, 1'b0, 3};
        vecs[1] = '{12'h080, -1, -1, 6, 1'b1, 1'b0, 3};
        vecs[2] = '{12'h004, -1, -1, 4, 1'b0, 1'b1, 0};
        vecs[3] = '{12'h600, -1, -1, 7, 1'b1, 1'b0, 3};
        vecs[4] = '{12'h020, -1, -1, 5, 1'b0, 1'b1, 1};
        vecs[5] = '{12'h000, 16, 11, 4, 1'b1, 1'b0, 3};
        vecs[6] = '{12'h000,  5, -1, 4, 1'b1, 1'b0, 3};

        rom[0] = 24'h3103_11;
        rom[1] = 24'h3008_82;
        rom[2] = 24'h3008_42;
        rom[3] = 24'h4740_20;

        reset_n = 1'b0;
        start   = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {sccb_req, busy, init_done, init_error, progress, table_addr, sccb_reg_addr, sccb_wdata},
            44'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_req", {sccb_req, busy, init_done, init_error}, 4'b0000);

        for (int i = 0; i < 7; i++) begin
            build_plan(vecs[i].nk);
            run_and_check($sformatf("vec%0d", i), vecs[i].bso, vecs[i].spur);
            chk($sformatf("vec%0d_tbl_reqs", i), 64'(req_cyc.size()), 64'(vecs[i].reqs));
            chk($sformatf("vec%0d_tbl_flags", i), {init_done, init_error}, {vecs[i].done, vecs[i].err});
            chk($sformatf("vec%0d_tbl_prog", i), 64'(progress), 64'(vecs[i].prog));
            if (i == 0) begin
                if (req_cyc.size() >= 4) begin
                    chk("first_req_latency", 64'(req_cyc[0] - last_s), 64'd13);
                    chk("gap_after_swrst", 64'(req_cyc[2] - req_cyc[1] - LAT), 64'd24);
                    chk("gap_no_settle", 64'(req_cyc[3] - req_cyc[2] - LAT), 64'd4);
                end else begin
                    chk("gap_req_count", 64'(req_cyc.size()), 64'd4);
                end
            end
        end

        // Reset while waiting on entry 2, then restart.
        build_plan(12'h000);
        req_cyc.delete();
        req_addr.delete();
        req_dat.delete();
        rsp_p = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        b = 0;
        while (req_cyc.size() < 3 && b < 500) begin
            @(negedge clk);
            b++;
        end
        chk("rst_reached_entry2", 64'(req_cyc.size()), 64'd3);
        repeat (2) @(negedge clk);
        chk("rst_progress_before", 64'(progress), 64'd2);
        reset_n = 1'b0;
        #1;
        chk("rst_async_outputs",
            {sccb_req, busy, init_done, init_error, progress, table_addr, sccb_reg_addr, sccb_wdata},
            44'h0);
        repeat (3) @(negedge clk);
        chk("rst_held_outputs",
            {sccb_req, busy, init_done, init_error, progress, table_addr, sccb_reg_addr, sccb_wdata},
            44'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_idle", {sccb_req, busy, init_done, init_error, progress}, 12'h0);
        run_and_check("after_reset", -1, -1);

        for (int r = 0; r < 8; r++) begin
            for (int e = 0; e < NREG; e++) begin
                rom[e] = {(($urandom_range(0, 1) == 1) ? 16'h3008 : 16'($urandom)), 8'($urandom)};
            end
            plan_nack.delete();
            plan_lat.delete();
            for (int k = 0; k < 40; k++) begin
                plan_nack.push_back($urandom_range(0, 2) == 0);
                plan_lat.push_back(int'($urandom_range(1, 8)));
            end
            run_and_check($sformatf("rand%0d", r), -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
